// File: rtl/gpp_boot_ctrl.sv
// -----------------------------------------------------------------------------
// gpp_boot_ctrl
//   Host-side boot sequencer for the GPP. Owns port B of the program/data SRAM
//   and the core reset. A run is: stream a program image into SRAM starting at
//   address 0 (core held in reset), release the core until Done or timeout,
//   put the core back in reset, then read a result window out of SRAM onto a
//   ready/valid stream.
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   start_i               start pulse, honoured only in IDLE
//   load_len_i            words to load at address 0 (sampled on start)
//   dump_base_i           first dump address (sampled on start)
//   dump_len_i            words to dump (sampled on start)
//   h_wr_valid_i/ready_o  load stream handshake, h_wr_data_i = load word
//   core_rst_o            GPP core reset, 1 = held
//   core_done_i           GPP Done
//   mb_addr_o/di_o/en_o/we_o, mb_do_i   SRAM port B (1-cycle read latency)
//   rd_valid_o/rd_ready_i dump stream handshake, rd_data_o = dump word
//   busy_o                high outside IDLE
//   fin_o                 one-cycle completion pulse
//   timeout_o             sticky: last run ended by the cycle limit
//   run_cycles_o          cycles the core spent out of reset (saturating)
// -----------------------------------------------------------------------------
module gpp_boot_ctrl #(
  parameter int DW  = 32,
  parameter int AW  = 10,
  parameter int TMO = 1000000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW:0]   load_len_i,
  input  logic [AW-1:0] dump_base_i,
  input  logic [AW:0]   dump_len_i,
  input  logic          h_wr_valid_i,
  output logic          h_wr_ready_o,
  input  logic [DW-1:0] h_wr_data_i,
  output logic          core_rst_o,
  input  logic          core_done_i,
  output logic [AW-1:0] mb_addr_o,
  output logic [DW-1:0] mb_di_o,
  input  logic [DW-1:0] mb_do_i,
  output logic          mb_en_o,
  output logic          mb_we_o,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic [DW-1:0] rd_data_o,
  output logic          busy_o,
  output logic          fin_o,
  output logic          timeout_o,
  output logic [31:0]   run_cycles_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DISS, S_DCAP, S_DHOLD, S_FIN
  } state_e;

  // Exit compare is against the pre-increment count, so the core gets
  // exactly TMO cycles out of reset.
  localparam logic [31:0] TMO_LIM = 32'(TMO - 1);

  state_e        state_q, state_d;
  logic [AW:0]   load_len_q, dump_len_q;
  logic [AW:0]   cnt_q;       // load word count, reused as dump word count
  logic [AW-1:0] dptr_q;      // dump address, wraps mod 2^AW
  logic [DW-1:0] rd_data_q;
  logic [31:0]   run_cyc_q;
  logic          tmo_q;

  logic wr_hs, rd_hs, tmo_hit, run_exit, load_last, dump_last;

  assign wr_hs     = (state_q == S_LOAD)  && h_wr_valid_i;
  assign rd_hs     = (state_q == S_DHOLD) && rd_ready_i;
  assign tmo_hit   = (TMO != 0) && (run_cyc_q == TMO_LIM);
  assign run_exit  = (state_q == S_RUN) && (core_done_i || tmo_hit);
  assign load_last = wr_hs && ((cnt_q + (AW+1)'(1)) == load_len_q);
  assign dump_last = rd_hs && ((cnt_q + (AW+1)'(1)) == dump_len_q);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = (load_len_i == '0) ? S_RUN : S_LOAD;
      S_LOAD:  if (load_last) state_d = S_RUN;
      S_RUN:   if (run_exit) state_d = (dump_len_q != '0) ? S_DISS : S_FIN;
      S_DISS:  state_d = S_DCAP;
      S_DCAP:  state_d = S_DHOLD;
      S_DHOLD: if (rd_hs) state_d = dump_last ? S_FIN : S_DISS;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (all decoded from state so reset clears them immediately)
  // ---------------------------------------------------------------------------
  always_comb begin
    h_wr_ready_o = 1'b0;
    mb_en_o      = 1'b0;
    mb_we_o      = 1'b0;
    mb_addr_o    = '0;
    mb_di_o      = '0;
    rd_valid_o   = 1'b0;
    core_rst_o   = 1'b1;
    fin_o        = 1'b0;
    busy_o       = (state_q != S_IDLE);
    case (state_q)
      S_LOAD: begin
        h_wr_ready_o = 1'b1;
        mb_en_o      = h_wr_valid_i;
        mb_we_o      = h_wr_valid_i;
        mb_addr_o    = cnt_q[AW-1:0];   // image longer than SRAM wraps
        mb_di_o      = h_wr_data_i;
      end
      S_RUN:   core_rst_o = 1'b0;
      S_DISS: begin
        mb_en_o   = 1'b1;
        mb_addr_o = dptr_q;
      end
      S_DHOLD: rd_valid_o = 1'b1;
      S_FIN:   fin_o = 1'b1;
      default: ;
    endcase
  end

  assign rd_data_o    = rd_data_q;
  assign timeout_o    = tmo_q;
  assign run_cycles_o = run_cyc_q;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      load_len_q <= '0;
      dump_len_q <= '0;
      cnt_q      <= '0;
      dptr_q     <= '0;
      rd_data_q  <= '0;
      run_cyc_q  <= '0;
      tmo_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          load_len_q <= load_len_i;
          dump_len_q <= dump_len_i;
          dptr_q     <= dump_base_i;
          cnt_q      <= '0;
          run_cyc_q  <= '0;
          tmo_q      <= 1'b0;
        end
        S_LOAD: if (wr_hs) cnt_q <= cnt_q + (AW+1)'(1);
        S_RUN: begin
          if (run_cyc_q != '1) run_cyc_q <= run_cyc_q + 32'd1;
          if (run_exit) begin
            cnt_q <= '0;                       // becomes the dump count
            if (tmo_hit && !core_done_i) tmo_q <= 1'b1;  // Done wins a tie
          end
        end
        S_DCAP: rd_data_q <= mb_do_i;         // read data lands one cycle after issue
        S_DHOLD: if (rd_hs) begin
          dptr_q <= dptr_q + AW'(1);
          cnt_q  <= cnt_q + (AW+1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpp_boot_ctrl.sv
`timescale 1ns/1ps
module tb_gpp_boot_ctrl;
  localparam int DW = 32, AW = 10, TMO = 20, DEPTH = 1 << AW;

  logic          clk, rst, start;
  logic [AW:0]   load_len, dump_len;
  logic [AW-1:0] dump_base;
  logic          h_wr_valid, h_wr_ready;
  logic [DW-1:0] h_wr_data;
  logic          core_rst, core_done;
  logic [AW-1:0] mb_addr;
  logic [DW-1:0] mb_di, mb_do;
  logic          mb_en, mb_we, rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          busy, fin, timeout;
  logic [31:0]   run_cycles;

  gpp_boot_ctrl #(.DW(DW), .AW(AW), .TMO(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .load_len_i(load_len),
    .dump_base_i(dump_base), .dump_len_i(dump_len), .h_wr_valid_i(h_wr_valid),
    .h_wr_ready_o(h_wr_ready), .h_wr_data_i(h_wr_data), .core_rst_o(core_rst),
    .core_done_i(core_done), .mb_addr_o(mb_addr), .mb_di_o(mb_di), .mb_do_i(mb_do),
    .mb_en_o(mb_en), .mb_we_o(mb_we), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .rd_data_o(rd_data), .busy_o(busy), .fin_o(fin), .timeout_o(timeout),
    .run_cycles_o(run_cycles)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end

  // SRAM port B model plus a bench-side preload path
  logic [DW-1:0] mem [DEPTH];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mb_en) begin
      if (mb_we) mem[mb_addr] <= mb_di;
      else       mb_do <= mem[mb_addr];
    end
  end

  // Bus monitors (only ever read by the tests, as before/after snapshots)
  int en_cnt = 0, wr_cnt = 0, hs_cnt = 0, stray_we = 0;
  int rd_addr_q[$];
  always @(posedge clk) begin
    if (mb_en) en_cnt <= en_cnt + 1;
    if (mb_en && mb_we) wr_cnt <= wr_cnt + 1;
    if (mb_we && !h_wr_ready) stray_we <= stray_we + 1;
    if (rd_valid && rd_ready) hs_cnt <= hs_cnt + 1;
    if (mb_en && !mb_we) rd_addr_q.push_back(int'(mb_addr));
  end

  logic [DW-1:0] exp_mem [DEPTH];   // what the SRAM must hold, from stimulus
  int total = 0, bad = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  task automatic preload(input int a, input logic [DW-1:0] d);
    @(negedge clk); pl_en = 1; pl_addr = AW'(a); pl_data = d;
    @(negedge clk); pl_en = 0;
    exp_mem[a % DEPTH] = d;
  endtask

  task automatic pulse_start(input int ll, input int db, input int dl);
    @(negedge clk);
    start = 1; load_len = (AW+1)'(ll); dump_base = AW'(db); dump_len = (AW+1)'(dl);
    @(negedge clk);
    start = 0;
  endtask

  // vmode 0: continuous, 1: alternating 1,0,1,0, 2: random. dbase != 0 gives dbase+k data.
  task automatic load_words(input int n, input int vmode, input logic [DW-1:0] dbase);
    int k = 0, cyc = 0;
    while (k < n && cyc < 5000) begin
      h_wr_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : ($urandom_range(99) < 70);
      h_wr_data  = (dbase != 0) ? dbase + DW'(k) : $urandom;
      #1;
      total++;
      if (h_wr_ready !== 1'b1 || core_rst !== 1'b1 || mb_en !== h_wr_valid || mb_we !== h_wr_valid ||
          (h_wr_valid && (mb_addr !== AW'(k % DEPTH) || mb_di !== h_wr_data))) begin
        bad++;
        $display("FAIL load_word%0d: got rdy=%b crst=%b en=%b we=%b addr=%0h di=%0h want rdy=1 crst=1 en=we=%b addr=%0h di=%0h",
                 k, h_wr_ready, core_rst, mb_en, mb_we, mb_addr, mb_di, h_wr_valid, k % DEPTH, h_wr_data);
      end
      if (h_wr_valid) begin exp_mem[k % DEPTH] = h_wr_data; k++; end
      @(negedge clk); cyc++;
    end
    h_wr_valid = 0;
    if (k < n) begin total++; bad++; $display("FAIL load_bound: got %0d words want %0d", k, n); end
  endtask

  // Counts RUN cycles (core out of reset); done_at=0 never asserts Done.
  task automatic run_core(input int done_at, output int ncyc);
    ncyc = 0;
    while (core_rst === 1'b0 && ncyc < 200) begin
      ncyc++;
      core_done = (ncyc == done_at);
      @(negedge clk);
    end
    core_done = 0;
  endtask

  task automatic dump_words(input int base, input int n, input int hold, input bit rnd);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] exp = exp_mem[(base + i) % DEPTH];
      int w = 0, h = rnd ? $urandom_range(0, 3) : hold;
      while (rd_valid !== 1'b1 && w < 10) begin @(negedge clk); w++; end
      for (int c = 0; c <= h; c++) begin
        rd_ready = (c == h);
        #1;
        total++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
          bad++;
          $display("FAIL dump_word%0d: got v=%b d=%0h want v=1 d=%0h", i, rd_valid, rd_data, exp);
        end
        @(negedge clk);
      end
      rd_ready = 0;
    end
  endtask

  task automatic wait_fin(input string nm);
    int w = 0;
    while (fin !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    total++;
    if (fin !== 1'b1) begin bad++; $display("FAIL %s_fin: got 0 want 1", nm); end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1; start = 0; h_wr_valid = 0; h_wr_data = 0; core_done = 0; rd_ready = 0;
    load_len = 0; dump_len = 0; dump_base = 0; pl_en = 0; pl_addr = 0; pl_data = 0;
    #12;
    total++;
    if ({core_rst, busy, h_wr_ready, mb_en, mb_we, rd_valid, fin, timeout} !== 8'b1000_0000) begin
      bad++; $display("FAIL reset_ctl: got %b want 10000000",
                      {core_rst, busy, h_wr_ready, mb_en, mb_we, rd_valid, fin, timeout});
    end
    total++;
    if (mb_addr !== '0 || mb_di !== '0 || rd_data !== '0 || run_cycles !== '0) begin
      bad++; $display("FAIL reset_data: got addr=%0h di=%0h rd=%0h rc=%0d want all 0",
                      mb_addr, mb_di, rd_data, run_cycles);
    end
    @(negedge clk); rst = 0;
    for (int a = 0; a < DEPTH; a++) preload(a, DW'(a * 7 + 3));
  endtask

  task automatic test_load_run();
    int n;
    pulse_start(4, 0, 0);
    load_words(4, 0, 32'hA0);
    total++;
    if (core_rst !== 1'b0) begin bad++; $display("FAIL lr_core_rel: got %b want 0", core_rst); end
    run_core(10, n);
    total++;
    if (n != 10) begin bad++; $display("FAIL lr_run_len: got %0d want 10", n); end
    total++;
    if (fin !== 1'b1 || run_cycles !== 32'd10 || timeout !== 1'b0 || core_rst !== 1'b1) begin
      bad++; $display("FAIL lr_end: got fin=%b rc=%0d to=%b crst=%b want 1 10 0 1", fin, run_cycles, timeout, core_rst);
    end
    @(negedge clk);
    total++;
    if (fin !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL lr_idle: got fin=%b busy=%b want 0 0", fin, busy); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[i] !== 32'hA0 + i) begin bad++; $display("FAIL lr_mem%0d: got %0h want %0h", i, mem[i], 32'hA0 + i); end
    end
  endtask

  task automatic test_throttled();
    int n, w0 = wr_cnt;
    pulse_start(5, 0, 0);
    load_words(5, 1, 0);
    total++;
    if (wr_cnt - w0 != 5) begin bad++; $display("FAIL thr_writes: got %0d want 5", wr_cnt - w0); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (mem[i] !== exp_mem[i]) begin bad++; $display("FAIL thr_mem%0d: got %0h want %0h", i, mem[i], exp_mem[i]); end
    end
    run_core(3, n);
    wait_fin("thr");
  endtask

  task automatic test_dump();
    int n, q0, h0;
    preload(10'h3FE, $urandom); preload(10'h3FF, $urandom); preload(0, $urandom);
    q0 = rd_addr_q.size(); h0 = hs_cnt;
    pulse_start(0, 'h3FE, 3);
    run_core(1, n);
    dump_words('h3FE, 3, 5, 0);
    total++;
    if (fin !== 1'b1) begin bad++; $display("FAIL dmp_fin: got %b want 1", fin); end
    total++;
    if (hs_cnt - h0 != 3) begin bad++; $display("FAIL dmp_hs: got %0d want 3", hs_cnt - h0); end
    total++;
    if (rd_addr_q.size() - q0 != 3 || rd_addr_q[q0] != 'h3FE || rd_addr_q[q0+1] != 'h3FF || rd_addr_q[q0+2] != 0) begin
      bad++; $display("FAIL dmp_addrs: got %0d reads want 3fe,3ff,0", rd_addr_q.size() - q0);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    pulse_start(0, 0, 0);
    run_core(0, n);
    total++;
    if (n != 20 || timeout !== 1'b1 || run_cycles !== 32'd20 || core_rst !== 1'b1 || fin !== 1'b1) begin
      bad++; $display("FAIL tmo_limit: got n=%0d to=%b rc=%0d crst=%b fin=%b want 20 1 20 1 1", n, timeout, run_cycles, core_rst, fin);
    end
    @(negedge clk);
    pulse_start(0, 0, 0);
    total++;
    if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_clear: got %b want 0", timeout); end
    run_core(20, n);
    total++;
    if (n != 20 || timeout !== 1'b0 || run_cycles !== 32'd20) begin
      bad++; $display("FAIL tmo_tie: got n=%0d to=%b rc=%0d want 20 0 20", n, timeout, run_cycles);
    end
    @(negedge clk);
  endtask

  task automatic test_edge();
    int h0 = hs_cnt;
    pulse_start(0, 0, 0);
    total++;
    if (core_rst !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL edge_len0: got crst=%b busy=%b want 0 1", core_rst, busy); end
    for (int c = 1; c <= 8; c++) begin
      start = (c == 3); load_len = 5; dump_len = 2; dump_base = 7;
      core_done = (c == 8);
      #1;
      total++;
      if (run_cycles !== 32'(c - 1) || core_rst !== 1'b0) begin
        bad++; $display("FAIL edge_run_c%0d: got rc=%0d crst=%b want %0d 0", c, run_cycles, core_rst, c - 1);
      end
      @(negedge clk);
    end
    start = 0; core_done = 0;
    total++;
    if (fin !== 1'b1 || run_cycles !== 32'd8 || hs_cnt != h0) begin
      bad++; $display("FAIL edge_ignore: got fin=%b rc=%0d hs=%0d want 1 8 0", fin, run_cycles, hs_cnt - h0);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int n, w = 0, e0;
    preload(5, $urandom); preload(6, $urandom);
    pulse_start(0, 5, 2);
    run_core(1, n);
    while (rd_valid !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    #2 rst = 1;
    #1;
    e0 = en_cnt;
    total++;
    if ({core_rst, busy, rd_valid, mb_en, fin} !== 5'b10000 || rd_data !== '0 || run_cycles !== '0) begin
      bad++; $display("FAIL arst_now: got ctl=%b rd=%0h rc=%0d want 10000 0 0",
                      {core_rst, busy, rd_valid, mb_en, fin}, rd_data, run_cycles);
    end
    @(negedge clk); @(negedge clk);
    rst = 0;
    total++;
    if (en_cnt != e0) begin bad++; $display("FAIL arst_quiet: got %0d accesses want 0", en_cnt - e0); end
    pulse_start(2, 0, 0);
    load_words(2, 0, 32'h55);
    run_core(2, n);
    wait_fin("arst");
  endtask

  task automatic test_overflow();
    int n;
    pulse_start(DEPTH + 2, 0, 0);
    load_words(DEPTH + 2, 2, 0);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (mem[i] !== exp_mem[i]) begin bad++; $display("FAIL ovf_wrap%0d: got %0h want %0h", i, mem[i], exp_mem[i]); end
    end
    run_core(1, n);
    wait_fin("ovf");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int ll = $urandom_range(1, 8), db = $urandom_range(0, DEPTH - 1), dl = $urandom_range(0, 4);
      int da = $urandom_range(1, 25), n;
      int en = (da <= TMO) ? da : TMO;
      pulse_start(ll, db, dl);
      load_words(ll, 2, 0);
      run_core(da, n);
      total++;
      if (n != en || run_cycles !== 32'(en) || timeout !== (da > TMO)) begin
        bad++; $display("FAIL rnd%0d_run: got n=%0d rc=%0d to=%b want %0d %0d %b", it, n, run_cycles, timeout, en, en, da > TMO);
      end
      if (dl > 0) dump_words(db, dl, 0, 1);
      wait_fin("rnd");
    end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_throttled();
    test_dump();
    test_timeout();
    test_edge();
    test_async_reset();
    test_overflow();
    test_random();
    total++;
    if (stray_we != 0) begin bad++; $display("FAIL stray_we: got %0d want 0", stray_we); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
